fft_ram_wr: RTL and testbench

//  Consumer end of the FFT start/stop handshake. While fft_valid (from fft_ctrl) is high, captures one
//  FFT output frame (re/im stream), computes |X|^2 per bin in a 2-stage pipeline and writes it to the

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft_mag_sq.sv | 55 +++++
 rtl/fft_ram_wr.sv | 94 +++++++++
 tb/tb_fft_ram_wr.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared defaults and FSM state encoding for the FFT spectrum RAM writer.
package fft_pkg;

    localparam int N_POINT_DEF = 1024;
    localparam int DW_DEF      = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage re^2+im^2 pipeline; valid and address travel alongside the data.
// Latency 2 cycles, 1 sample/cycle, no back-pressure; flush kills both in-flight stages.
module fft_mag_sq #(
    parameter int DW = 16,
    parameter int AW = 10,
    parameter int MW = 2*DW+1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 sample_vld,
    input  logic signed [DW-1:0] sample_re,
    input  logic signed [DW-1:0] sample_im,
    input  logic [AW-1:0]        sample_addr,
    output logic                 stage1_vld,
    output logic                 mag_vld,
    output logic [AW-1:0]        mag_addr,
    output logic [MW-1:0]        mag_dat
);

    logic signed [2*DW-1:0] re_ext;
    logic signed [2*DW-1:0] im_ext;
    logic [2*DW-1:0]        re_sq;
    logic [2*DW-1:0]        im_sq;
    logic [AW-1:0]          s1_addr;

    // Squares are non-negative and below 2^(2*DW-1)+1, so the low 2*DW bits are exact.
    assign re_ext = (2*DW)'(sample_re);
    assign im_ext = (2*DW)'(sample_im);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_vld <= 1'b0;
            re_sq      <= '0;
            im_sq      <= '0;
            s1_addr    <= '0;
            mag_vld    <= 1'b0;
            mag_addr   <= '0;
            mag_dat    <= '0;
        end else begin
            stage1_vld <= sample_vld && !flush;
            mag_vld    <= stage1_vld && !flush;
            if (sample_vld) begin
                re_sq   <= $unsigned(re_ext * re_ext);
                im_sq   <= $unsigned(im_ext * im_ext);
                s1_addr <= sample_addr;
            end
            if (stage1_vld && !flush) begin
                mag_addr <= s1_addr;
                mag_dat  <= MW'(re_sq) + MW'(im_sq);
            end
        end
    end

endmodule

// File: rtl/fft_ram_wr.sv
// Captures one FFT frame while fft_valid is high and writes |X|^2 per bin to the spectrum RAM.
// Write 2 cycles after acceptance, shutdown pulse 1 cycle after the last write; no back-pressure.
module fft_ram_wr
    import fft_pkg::*;
#(
    parameter int N_POINT = N_POINT_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = $clog2(N_POINT),
    parameter int MW      = 2*DW+1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fft_valid,
    input  logic signed [DW-1:0] fft_re,
    input  logic signed [DW-1:0] fft_im,
    input  logic                 fft_dv,
    input  logic                 fft_last,
    output logic                 ram_wr_en,
    output logic [AW-1:0]        ram_wr_addr,
    output logic [MW-1:0]        ram_wr_data,
    output logic                 fft_shutdown,
    output logic                 frame_err
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [AW-1:0] bin_cnt;
    logic          last_bin;
    logic          accept;
    logic          abort;
    logic          stage1_vld;

    assign last_bin = (bin_cnt == AW'(N_POINT-1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (fft_valid) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!fft_valid)                         state_nxt = ST_IDLE;
                else if (accept && (last_bin || fft_last)) state_nxt = ST_DRAIN;
            end
            // The final bin sits in stage 1 for one cycle; once it leaves, its write is on the port.
            ST_DRAIN: begin
                if (!fft_valid)       state_nxt = ST_IDLE;
                else if (!stage1_vld) state_nxt = ST_DONE;
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept       = (state == ST_CAPTURE) && fft_valid && fft_dv;
        abort        = ((state == ST_CAPTURE) || (state == ST_DRAIN)) && !fft_valid;
        fft_shutdown = (state == ST_DONE);
    end

    // Clearing in IDLE covers both normal frame entry and recovery after an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) bin_cnt <= '0;
            else if (accept)      bin_cnt <= bin_cnt + AW'(1);
            if (accept && (fft_last != last_bin)) frame_err <= 1'b1;
        end
    end

    fft_mag_sq #(
        .DW (DW),
        .AW (AW),
        .MW (MW)
    ) u_mag_sq (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (abort),
        .sample_vld  (accept),
        .sample_re   (fft_re),
        .sample_im   (fft_im),
        .sample_addr (bin_cnt),
        .stage1_vld  (stage1_vld),
        .mag_vld     (ram_wr_en),
        .mag_addr    (ram_wr_addr),
        .mag_dat     (ram_wr_data)
    );

endmodule

// File: tb/tb_fft_ram_wr.sv
// Directed bench for fft_ram_wr: table-driven corner arithmetic plus multi-cycle frame sequences.
module tb_fft_ram_wr;

    localparam int NP = 1024;

    logic               clk;
    logic               rst_n;
    logic               fft_valid;
    logic signed [15:0] fft_re;
    logic signed [15:0] fft_im;
    logic               fft_dv;
    logic               fft_last;
    logic               ram_wr_en;
    logic [9:0]         ram_wr_addr;
    logic [32:0]        ram_wr_data;
    logic               fft_shutdown;
    logic               frame_err;

    fft_ram_wr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fft_valid    (fft_valid),
        .fft_re       (fft_re),
        .fft_im       (fft_im),
        .fft_dv       (fft_dv),
        .fft_last     (fft_last),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .fft_shutdown (fft_shutdown),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [32:0]        exp;
    } vec_t;

    vec_t   tbl [8];
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint wa_q[$], wd_q[$], wc_q[$], sd_q[$];
    longint ea_q[$], ed_q[$], ec_q[$], esd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_wr_en) begin
            wa_q.push_back(longint'(ram_wr_addr));
            wd_q.push_back(longint'(ram_wr_data));
            wc_q.push_back(longint'(cyc));
        end
        if (fft_shutdown) sd_q.push_back(longint'(cyc));
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [15:0] re, input logic signed [15:0] im,
                         input logic dv, input logic last, input logic acc,
                         input longint addr, input longint data);
        fft_re   = re;
        fft_im   = im;
        fft_dv   = dv;
        fft_last = last;
        if (acc) begin
            ea_q.push_back(addr);
            ed_q.push_back(data);
            ec_q.push_back(longint'(cyc + 2));
        end
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic arm();
        fft_valid = 1'b1;
        idle(1);
    endtask

    // Keeps fft_valid up through DRAIN and DONE, then releases it like fft_ctrl would.
    task automatic finish_frame();
        idle(3);
        fft_valid = 1'b0;
        idle(4);
    endtask

    task automatic check_sb(input string tag);
        chk({tag, ".nwr"}, longint'(wa_q.size()), longint'(ea_q.size()));
        for (int i = 0; i < wa_q.size() && i < ea_q.size(); i++) begin
            chk($sformatf("%s.addr[%0d]", tag, i), wa_q[i], ea_q[i]);
            chk($sformatf("%s.data[%0d]", tag, i), wd_q[i], ed_q[i]);
            chk($sformatf("%s.lat[%0d]", tag, i), wc_q[i], ec_q[i]);
        end
        chk({tag, ".nshut"}, longint'(sd_q.size()), longint'(esd_q.size()));
        for (int i = 0; i < sd_q.size() && i < esd_q.size(); i++)
            chk($sformatf("%s.shut[%0d]", tag, i), sd_q[i], esd_q[i]);
        wa_q.delete(); wd_q.delete(); wc_q.delete(); sd_q.delete();
        ea_q.delete(); ed_q.delete(); ec_q.delete(); esd_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".wr_en"}, longint'(ram_wr_en), 0);
        chk({tag, ".addr"},  longint'(ram_wr_addr), 0);
        chk({tag, ".data"},  longint'(ram_wr_data), 0);
        chk({tag, ".shut"},  longint'(fft_shutdown), 0);
        chk({tag, ".err"},   longint'(frame_err), 0);
    endtask

    initial begin
        tbl[0] = '{re: 16'sh8000, im: 16'sh8000, exp: 33'h0_8000_0000};
        tbl[1] = '{re: 16'sh7FFF, im: 16'sh0000, exp: 33'h0_3FFF_0001};
        tbl[2] = '{re: 16'sh0000, im: 16'sh8000, exp: 33'h0_4000_0000};
        tbl[3] = '{re: -16'sd1,   im: -16'sd1,   exp: 33'd2};
        tbl[4] = '{re: 16'sd3,    im: 16'sd4,    exp: 33'd25};
        tbl[5] = '{re: 16'sh8000, im: 16'sh7FFF, exp: 33'h0_7FFF_0001};
        tbl[6] = '{re: 16'sd100,  im: -16'sd200, exp: 33'd50000};
        tbl[7] = '{re: 16'sd0,    im: 16'sd0,    exp: 33'd0};

        rst_n = 1'b0; fft_valid = 1'b0; fft_re = '0; fft_im = '0; fft_dv = 1'b0; fft_last = 1'b0;
        idle(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Normal frame: re=k, im=0, last on the final bin.
        arm();
        for (int k = 0; k < NP; k++) begin
            if (k == NP-1) esd_q.push_back(longint'(cyc + 3));
            drive(16'(k), 16'sd0, 1'b1, k == NP-1, 1'b1, k, longint'(k) * k);
        end
        finish_frame();
        check_sb("normal");
        chk("normal.err", longint'(frame_err), 0);
        chk("hold.wr_en", longint'(ram_wr_en), 0);
        chk("hold.addr", longint'(ram_wr_addr), 1023);
        chk("hold.data", longint'(ram_wr_data), 1023 * 1023);

        // Corner arithmetic from the table, remainder re=k, im=-k.
        arm();
        for (int i = 0; i < 8; i++)
            drive(tbl[i].re, tbl[i].im, 1'b1, 1'b0, 1'b1, i, longint'(tbl[i].exp));
        for (int k = 8; k < NP; k++) begin
            if (k == NP-1) esd_q.push_back(longint'(cyc + 3));
            drive(16'(k), 16'(-k), 1'b1, k == NP-1, 1'b1, k, 2 * longint'(k) * k);
        end
        finish_frame();
        check_sb("table");
        chk("table.err", longint'(frame_err), 0);

        // Samples before enable, then random dv gaps with junk fft_last while dv=0.
        repeat (3) drive(16'sd77, 16'sd5, 1'b1, 1'b0, 1'b0, 0, 0);
        fft_valid = 1'b1;
        drive(16'sd99, 16'sd1, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < NP; ) begin
            if ($urandom_range(0, 1) == 1) begin
                if (k == NP-1) esd_q.push_back(longint'(cyc + 3));
                drive(16'(k), 16'sd1, 1'b1, k == NP-1, 1'b1, k, longint'(k) * k + 1);
                k++;
            end else begin
                drive(16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
            end
        end
        finish_frame();
        check_sb("gaps");
        chk("gaps.err", longint'(frame_err), 0);

        // Abort at bin 500: bin 499 is still in stage 1 and gets flushed.
        arm();
        for (int k = 0; k < 500; k++)
            drive(16'(k), 16'sd0, 1'b1, 1'b0, k < 499, k, longint'(k) * k);
        fft_valid = 1'b0;
        drive(16'sd500, 16'sd0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(5);
        check_sb("abort");

        // Early last at bin 10, also proving the next frame restarts at address 0.
        arm();
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) esd_q.push_back(longint'(cyc + 3));
            drive(16'(k + 1), 16'sd2, 1'b1, k == 10, 1'b1, k, longint'(k + 1) * (k + 1) + 4);
        end
        finish_frame();
        check_sb("early");
        chk("early.err", longint'(frame_err), 1);
        idle(5);
        chk("early.err_sticky", longint'(frame_err), 1);

        // Reset pulse at bin 300: bin 298 already on the port, bin 299 discarded.
        arm();
        for (int k = 0; k < 300; k++)
            drive(16'(k), 16'sd0, 1'b1, 1'b0, k < 299, k, longint'(k) * k);
        rst_n = 1'b0;
        drive(16'sd300, 16'sd0, 1'b1, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        fft_dv = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        @(posedge clk);
        #1;
        check_sb("midrst");

        // Fresh frame after reset, final bin without fft_last: still completes, flags error.
        for (int k = 0; k < NP; k++) begin
            if (k == NP-1) esd_q.push_back(longint'(cyc + 3));
            drive(16'(k), 16'sd0, 1'b1, 1'b0, 1'b1, k, longint'(k) * k);
        end
        finish_frame();
        check_sb("nolast");
        chk("nolast.err", longint'(frame_err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
